// File: rtl/lutram_xarray.sv
// Multi-read-port LUTRAM array (64-entry banks) with byte-enable writes and a clear sweep
// after reset or on request. Define LUTRAM_XARRAY_WBYPASS_EN to forward same-cycle writes to reads.
module lutram_xarray #(
    parameter int WIDTH    = 512,
    parameter int NENTRIES = 64,
    parameter int NREAD    = 3,
    parameter int AW       = $clog2(NENTRIES)
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   wen,
    input  logic [WIDTH/8-1:0]     wbe,
    input  logic [AW-1:0]          waddr,
    input  logic [WIDTH-1:0]       din,
    output logic                   wready,
    input  logic [NREAD*AW-1:0]    raddr,
    output logic [NREAD*WIDTH-1:0] dout,
    input  logic                   flush_req,
    output logic                   flush_busy,
    output logic                   flush_done
);

    localparam int NBANK = NENTRIES / 64;
    localparam int NBYTE = WIDTH / 8;

    typedef enum logic {
        IDLE  = 1'b0,
        SWEEP = 1'b1
    } state_e;

    state_e            state_q, state_d;
    logic [AW-1:0]     ctr_q, ctr_d;
    logic              done_q, done_d;
    logic              sweep_we;
    logic              wr_acc;
    logic [AW-1:0]     ra_c;
    logic [WIDTH-1:0]  rd_c;
    logic [WIDTH-1:0]  mem_q [NBANK][64];

    function automatic int bank_of(input logic [AW-1:0] a);
        return int'(a >> 6);
    endfunction

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= SWEEP;
            ctr_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ctr_q   <= ctr_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ctr_d   = ctr_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (flush_req) begin
                    state_d = SWEEP;
                    ctr_d   = '0;
                end
            end
            SWEEP: begin
                // flush_req is deliberately ignored here: a sweep never restarts
                if (ctr_q == AW'(NENTRIES - 1)) begin
                    state_d = IDLE;
                    ctr_d   = '0;
                    done_d  = 1'b1;
                end else begin
                    ctr_d = ctr_q + 1'b1;
                end
            end
            default: state_d = SWEEP;
        endcase
    end

    assign flush_busy = !reset_n || (state_q == SWEEP);
    assign wready     = !flush_busy;
    assign flush_done = done_q && reset_n;
    assign sweep_we   = reset_n && (state_q == SWEEP);
    assign wr_acc     = wen && wready;

    // Storage has no reset; the sweep is what defines its contents.
    always_ff @(posedge clk) begin
        for (int b = 0; b < NBANK; b++) begin
            if (sweep_we && bank_of(ctr_q) == b) begin
                mem_q[b][ctr_q[5:0]] <= '0;
            end
            for (int i = 0; i < NBYTE; i++) begin
                if (wr_acc && bank_of(waddr) == b && wbe[i]) begin
                    mem_q[b][waddr[5:0]][8*i +: 8] <= din[8*i +: 8];
                end
            end
        end
    end

    always_comb begin
        dout = '0;
        ra_c = '0;
        rd_c = '0;
        for (int k = 0; k < NREAD; k++) begin
            ra_c = raddr[k*AW +: AW];
            rd_c = '0;
            for (int b = 0; b < NBANK; b++) begin
                if (bank_of(ra_c) == b) begin
                    rd_c = mem_q[b][ra_c[5:0]];
                end
            end
`ifdef LUTRAM_XARRAY_WBYPASS_EN
            if (wr_acc && ra_c == waddr) begin
                for (int i = 0; i < NBYTE; i++) begin
                    if (wbe[i]) begin
                        rd_c[8*i +: 8] = din[8*i +: 8];
                    end
                end
            end
`endif
            dout[k*WIDTH +: WIDTH] = rd_c;
        end
    end

endmodule

// File: tb/tb_lutram_xarray.sv
// Bench for lutram_xarray (WIDTH=64, NENTRIES=128, NREAD=3): vector table, directed
// sweep/reset sequences and random traffic against an array-based reference model.
module tb_lutram_xarray;

    localparam int W  = 64;
    localparam int N  = 128;
    localparam int NR = 3;
    localparam int AW = 7;

    logic              clk = 1'b0;
    logic              reset_n;
    logic              wen;
    logic [W/8-1:0]    wbe;
    logic [AW-1:0]     waddr;
    logic [W-1:0]      din;
    logic              wready;
    logic [NR*AW-1:0]  raddr;
    logic [NR*W-1:0]   dout;
    logic              flush_req;
    logic              flush_busy;
    logic              flush_done;

    always #5 clk = ~clk;

    lutram_xarray #(.WIDTH(W), .NENTRIES(N), .NREAD(NR)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .wen        (wen),
        .wbe        (wbe),
        .waddr      (waddr),
        .din        (din),
        .wready     (wready),
        .raddr      (raddr),
        .dout       (dout),
        .flush_req  (flush_req),
        .flush_busy (flush_busy),
        .flush_done (flush_done)
    );

    int n_chk  = 0;
    int n_pass = 0;

    logic [W-1:0] model [N];

    typedef struct {
        logic [AW-1:0] wa;
        logic [7:0]    be;
        logic [W-1:0]  d;
        logic [AW-1:0] ra [NR];
        logic [W-1:0]  ex [NR];
    } vec_t;

    vec_t vt [6];

    int           cnt_busy, cnt_nrdy;
    logic [W-1:0] e;
    logic [AW-1:0] a;

    function automatic logic [W-1:0] merge(input logic [W-1:0] old, input logic [W-1:0] nw,
                                           input logic [7:0] be);
        logic [W-1:0] r;
        r = old;
        for (int i = 0; i < 8; i++) if (be[i]) r[8*i +: 8] = nw[8*i +: 8];
        return r;
    endfunction

    task automatic check(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    task automatic set_rd(input int k, input logic [AW-1:0] ad);
        raddr[k*AW +: AW] = ad;
    endtask

    function automatic logic [W-1:0] rd(input int k);
        return dout[k*W +: W];
    endfunction

    task automatic set_vec(input int i, input logic [AW-1:0] wa, input logic [7:0] be,
                           input logic [W-1:0] d,
                           input logic [AW-1:0] r0, input logic [AW-1:0] r1, input logic [AW-1:0] r2,
                           input logic [W-1:0] e0, input logic [W-1:0] e1, input logic [W-1:0] e2);
        vt[i].wa = wa; vt[i].be = be; vt[i].d = d;
        vt[i].ra[0] = r0; vt[i].ra[1] = r1; vt[i].ra[2] = r2;
        vt[i].ex[0] = e0; vt[i].ex[1] = e1; vt[i].ex[2] = e2;
    endtask

    // Counts busy cycles (sampled on falling edges) until the sweep ends; optionally
    // pulses flush_req at a given busy cycle to show it is ignored mid-sweep.
    task automatic wait_sweep(input int pulse_at, output int nbusy, output int nnrdy);
        nbusy = 0;
        nnrdy = 0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (!flush_busy) break;
            nbusy++;
            if (!wready) nnrdy++;
            flush_req = (pulse_at != 0) && (nbusy == pulse_at);
        end
        flush_req = 1'b0;
    endtask

    task automatic clear_model();
        for (int i = 0; i < N; i++) model[i] = '0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        set_vec(0, 7'd63,  8'hFF, 64'h1122334455667788, 7'd63, 7'd0,  7'd127,
                64'h1122334455667788, 64'h0, 64'h0);
        set_vec(1, 7'd64,  8'hFF, 64'hAABBCCDDEEFF0011, 7'd63, 7'd64, 7'd63,
                64'h1122334455667788, 64'hAABBCCDDEEFF0011, 64'h1122334455667788);
        set_vec(2, 7'd5,   8'hFF, 64'hFFFFFFFFFFFFFFFF, 7'd5,  7'd4,  7'd6,
                64'hFFFFFFFFFFFFFFFF, 64'h0, 64'h0);
        set_vec(3, 7'd5,   8'h0F, 64'h0,                7'd5,  7'd64, 7'd63,
                64'hFFFFFFFF00000000, 64'hAABBCCDDEEFF0011, 64'h1122334455667788);
        set_vec(4, 7'd5,   8'h00, 64'h1234,             7'd5,  7'd5,  7'd5,
                64'hFFFFFFFF00000000, 64'hFFFFFFFF00000000, 64'hFFFFFFFF00000000);
        set_vec(5, 7'd127, 8'hA5, 64'h0102030405060708, 7'd127, 7'd64, 7'd0,
                64'h0100030000060008, 64'hAABBCCDDEEFF0011, 64'h0);

        reset_n = 1'b0; wen = 1'b0; wbe = '0; waddr = '0; din = '0;
        raddr = '0; flush_req = 1'b0;

        // reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy",  64'(flush_busy), 64'd1);
        check("rst_wready", 64'(wready),    64'd0);
        check("rst_done",  64'(flush_done), 64'd0);

        // release: exactly N busy cycles, then one done pulse
        @(posedge clk); #1 reset_n = 1'b1;
        wait_sweep(0, cnt_busy, cnt_nrdy);
        check("init_sweep_len", 64'(cnt_busy), 64'(N));
        check("init_done",      64'(flush_done), 64'd1);
        clear_model();
        @(negedge clk);
        check("init_done_drop", 64'(flush_done), 64'd0);

        for (int j = 0; j < 3; j++) begin
            a = (j == 0) ? 7'd0 : (j == 1) ? 7'd64 : 7'd127;
            for (int k = 0; k < NR; k++) set_rd(k, a);
            #1;
            for (int k = 0; k < NR; k++) check($sformatf("zero_a%0d_p%0d", a, k), rd(k), 64'h0);
        end

        // table-driven writes, read back after the write edge
        for (int v = 0; v < 6; v++) begin
            @(posedge clk); #1;
            wen = 1'b1; waddr = vt[v].wa; wbe = vt[v].be; din = vt[v].d;
            @(posedge clk); #1;
            wen = 1'b0;
            model[vt[v].wa] = merge(model[vt[v].wa], vt[v].d, vt[v].be);
            for (int k = 0; k < NR; k++) set_rd(k, vt[v].ra[k]);
            #1;
            for (int k = 0; k < NR; k++) check($sformatf("vec%0d_p%0d", v, k), rd(k), vt[v].ex[k]);
        end

        // same-cycle read/write to address 9
        @(posedge clk); #1;
        wen = 1'b1; waddr = 7'd9; wbe = 8'h01; din = 64'hFF;
        set_rd(0, 7'd9); set_rd(1, 7'd10);
        #1;
`ifdef LUTRAM_XARRAY_WBYPASS_EN
        check("rw9_same_cycle", rd(0), 64'hFF);
`else
        check("rw9_same_cycle", rd(0), 64'h00);
`endif
        check("rw9_other_port", rd(1), 64'h0);
        @(posedge clk); #1;
        wen = 1'b0;
        model[9] = 64'hFF;
        #1;
        check("rw9_next_cycle", rd(0), 64'hFF);

        // random traffic against the model
        for (int it = 0; it < 200; it++) begin
            @(posedge clk); #1;
            wen   = 1'($urandom_range(0, 1));
            waddr = AW'($urandom_range(0, N - 1));
            wbe   = 8'($urandom);
            din   = {$urandom, $urandom};
            for (int k = 0; k < NR; k++) set_rd(k, AW'($urandom_range(0, N - 1)));
            if (it % 4 == 0) set_rd(0, waddr);
            #1;
            for (int k = 0; k < NR; k++) begin
                a = raddr[k*AW +: AW];
                e = model[a];
`ifdef LUTRAM_XARRAY_WBYPASS_EN
                if (wen && a == waddr) e = merge(e, din, wbe);
`endif
                check($sformatf("rand%0d_p%0d", it, k), rd(k), e);
            end
            if (wen) model[waddr] = merge(model[waddr], din, wbe);
        end
        @(posedge clk); #1;
        wen = 1'b0;

        // flush with a write held high, plus an ignored flush_req mid-sweep
        @(posedge clk); #1;
        wen = 1'b1; waddr = 7'd20; wbe = 8'hFF; din = 64'hDEADBEEFCAFEF00D;
        flush_req = 1'b1;
        @(posedge clk); #1;
        flush_req = 1'b0;
        wait_sweep(10, cnt_busy, cnt_nrdy);
        check("traffic_sweep_len", 64'(cnt_busy), 64'(N));
        check("traffic_wready_low", 64'(cnt_nrdy), 64'(N));
        check("traffic_done",      64'(flush_done), 64'd1);
        check("traffic_wready_up", 64'(wready),     64'd1);
        @(posedge clk); #1;
        wen = 1'b0;
        clear_model();
        model[20] = 64'hDEADBEEFCAFEF00D;
        for (int i = 0; i < N; i++) begin
            set_rd(0, AW'(i));
            #1;
            check($sformatf("post_flush_a%0d", i), rd(0), model[i]);
        end

        // reset in the middle of a sweep
        @(posedge clk); #1;
        wen = 1'b1; waddr = 7'd10; wbe = 8'hFF; din = 64'h0123456789ABCDEF;
        @(posedge clk); #1;
        waddr = 7'd100; din = 64'h5555AAAA5555AAAA;
        @(posedge clk); #1;
        wen = 1'b0;
        flush_req = 1'b1;
        @(posedge clk); #1;
        flush_req = 1'b0;
        repeat (30) @(posedge clk);
        #1;
        set_rd(0, 7'd10); set_rd(1, 7'd100); set_rd(2, 7'd29);
        #1;
        check("mid_below_ctr", rd(0), 64'h0);
        check("mid_stale",     rd(1), 64'h5555AAAA5555AAAA);
        check("mid_edge29",    rd(2), 64'h0);
        reset_n = 1'b0;
        #1;
        check("mid_rst_busy",   64'(flush_busy), 64'd1);
        check("mid_rst_wready", 64'(wready),     64'd0);
        check("mid_rst_done",   64'(flush_done), 64'd0);
        @(posedge clk);
        @(posedge clk); #1;
        reset_n = 1'b1;
        wait_sweep(0, cnt_busy, cnt_nrdy);
        check("restart_sweep_len", 64'(cnt_busy), 64'(N));
        check("restart_done",      64'(flush_done), 64'd1);
        #1;
        check("restart_a10",  rd(0), 64'h0);
        check("restart_a100", rd(1), 64'h0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
